trng_sched: RTL and testbench

//  Sequencer and sharing front-end for the trng core.
//  - Loads seeds into the core and holds it in reset for a fixed time.
//  - Discards a warm-up stream, then packs o_valid-qualified o_warbler bits into words.
//  - Health-checks the raw stream and buffers words in a small FIFO.
//  - Hands words round-robin to N_REQ consumers. Sits between trng and the system bus clients.

---
 rtl/trng_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/trng_sched.sv | 168 ++++++++++++++++
 tb/tb_trng_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared types and defaults for the trng sequencer front-end.
package trng_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESEED = 3'd1,
    ST_WARMUP = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4
  } trng_st_e;

  localparam int WORD_W_DEF = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// then moves the pointer just past the winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] cand;
  logic [N-1:0]  pick;
  logic          found;

  always_comb begin
    pick     = '0;
    found    = 1'b0;
    cand     = '0;
    ptr_next = ptr_reg;
    for (int k = 0; k < N; k++) begin
      cand = PW'((int'(ptr_reg) + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        pick[cand]  = 1'b1;
        ptr_next    = PW'((int'(cand) + 1) % N);
      end
    end
  end

  assign gnt = en ? pick : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg <= '0;
    end else if (en && found) begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/trng_sched.sv
// Sequencer and sharing front-end for the trng core: reseed, warm-up,
// health test, bit packing, word FIFO and round-robin hand-out.
module trng_sched
  import trng_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WORD_W    = WORD_W_DEF,
  parameter int FIFO_D    = 4,
  parameter int RST_CYC   = 8,
  parameter int WARMUP    = 256,
  parameter int REP_LIMIT = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        seed_load,
  input  logic                        seed_d1,
  input  logic                        seed_d2,
  input  logic [4:0]                  seed_d3,
  output logic                        trng_rst,
  output logic                        trng_d1,
  output logic                        trng_d2,
  output logic [4:0]                  trng_d3,
  input  logic                        trng_valid,
  input  logic                        trng_bit,
  input  logic [N_REQ-1:0]            req,
  output logic [N_REQ-1:0]            gnt,
  output logic [WORD_W-1:0]           rnd_data,
  output logic                        rnd_valid,
  output logic [$clog2(FIFO_D):0]     fifo_level,
  output logic                        fault,
  output logic [2:0]                  st
);

  localparam int AW  = $clog2(FIFO_D);
  localparam int LW  = AW + 1;
  localparam int RCW = $clog2(RST_CYC + 1);
  localparam int WCW = $clog2(WARMUP + 1);
  localparam int RLW = $clog2(REP_LIMIT + 1);
  localparam int BCW = $clog2(WORD_W + 1);

  trng_st_e          state_reg, state_next;
  logic [RCW-1:0]    rcnt_reg;
  logic [WCW-1:0]    wcnt_reg;
  logic [RLW-1:0]    run_cnt_reg, run_next;
  logic              last_bit_reg;
  logic [WORD_W-2:0] pack_reg;
  logic [BCW-1:0]    bit_cnt_reg;

  logic [WORD_W-1:0] mem [FIFO_D];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]     level_reg;

  logic health_on, fault_hit, flush, word_done, push, pop, full, empty, arb_en;
  logic [WORD_W-1:0] word_in;

  assign health_on = (state_reg == ST_WARMUP) || (state_reg == ST_RUN);
  assign full      = (level_reg == LW'(FIFO_D));
  assign empty     = (level_reg == '0);
  assign word_in   = {pack_reg, trng_bit};

  always_comb begin
    state_next = state_reg;
    run_next   = run_cnt_reg;
    fault_hit  = 1'b0;
    if (health_on && trng_valid) begin
      if (run_cnt_reg != '0 && trng_bit == last_bit_reg) run_next = run_cnt_reg + 1'b1;
      else run_next = RLW'(1);
      fault_hit = (run_next == RLW'(REP_LIMIT));
    end
    case (state_reg)
      ST_RESEED: if (rcnt_reg == RCW'(RST_CYC - 1)) state_next = ST_WARMUP;
      ST_WARMUP: begin
        if (fault_hit) state_next = ST_FAULT;
        else if (trng_valid && wcnt_reg == WCW'(WARMUP - 1)) state_next = ST_RUN;
      end
      ST_RUN:    if (fault_hit) state_next = ST_FAULT;
      default:   state_next = state_reg;
    endcase
    // Reseeding overrides every other transition, including a fault.
    if (seed_load) state_next = ST_RESEED;
  end

  assign flush     = seed_load || fault_hit;
  assign word_done = (state_reg == ST_RUN) && trng_valid &&
                     (bit_cnt_reg == BCW'(WORD_W - 1)) && !flush;
  assign pop       = |gnt;
  assign push      = word_done && (!full || pop);
  assign arb_en    = health_on && !empty && !seed_load;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .en  (arb_en),
    .gnt (gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      rcnt_reg     <= '0;
      wcnt_reg     <= '0;
      run_cnt_reg  <= '0;
      last_bit_reg <= 1'b0;
      pack_reg     <= '0;
      bit_cnt_reg  <= '0;
      trng_d1      <= 1'b0;
      trng_d2      <= 1'b0;
      trng_d3      <= '0;
    end else begin
      state_reg <= state_next;
      if (seed_load) begin
        trng_d1 <= seed_d1;
        trng_d2 <= seed_d2;
        trng_d3 <= seed_d3;
      end
      rcnt_reg <= (state_reg == ST_RESEED && state_next == ST_RESEED && !seed_load)
                  ? rcnt_reg + 1'b1 : '0;
      if (seed_load) wcnt_reg <= '0;
      else if (state_reg == ST_WARMUP && trng_valid) wcnt_reg <= wcnt_reg + 1'b1;
      if (flush) begin
        run_cnt_reg  <= '0;
        last_bit_reg <= 1'b0;
        pack_reg     <= '0;
        bit_cnt_reg  <= '0;
      end else begin
        if (health_on && trng_valid) begin
          run_cnt_reg  <= run_next;
          last_bit_reg <= trng_bit;
        end
        // A completed word restarts the packer whether or not it was stored.
        if (state_reg == ST_RUN && trng_valid) begin
          pack_reg    <= word_in[WORD_W-2:0];
          bit_cnt_reg <= (bit_cnt_reg == BCW'(WORD_W - 1)) ? '0 : bit_cnt_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_reg + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= word_in;
  end

  assign rnd_valid  = pop;
  assign rnd_data   = rnd_valid ? mem[rd_ptr_reg] : '0;
  assign fifo_level = level_reg;
  assign trng_rst   = (state_reg == ST_IDLE) || (state_reg == ST_RESEED) ||
                      (state_reg == ST_FAULT);
  assign fault      = (state_reg == ST_FAULT);
  assign st         = state_reg;

endmodule

// File: tb/tb_trng_sched.sv
// Self-checking bench for trng_sched: scoreboard of packed words, per-feature tasks.
module tb_trng_sched;
  import trng_pkg::*;

  localparam int N_REQ  = 4;
  localparam int WORD_W = 32;
  localparam int FIFO_D = 4;
  localparam int LW     = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              seed_load = 1'b0;
  logic              seed_d1 = 1'b0;
  logic              seed_d2 = 1'b0;
  logic [4:0]        seed_d3 = '0;
  logic              trng_rst, trng_d1, trng_d2;
  logic [4:0]        trng_d3;
  logic              trng_valid = 1'b0;
  logic              trng_bit = 1'b0;
  logic [N_REQ-1:0]  req = '0;
  logic [N_REQ-1:0]  gnt;
  logic [WORD_W-1:0] rnd_data;
  logic              rnd_valid;
  logic [LW-1:0]     fifo_level;
  logic              fault;
  logic [2:0]        st;

  int passed = 0;
  int total  = 0;
  logic [WORD_W-1:0] sb_q[$];
  logic [WORD_W-1:0] exp_w;

  always #5 clk = ~clk;

  trng_sched dut (
    .clk        (clk),
    .rst        (rst),
    .seed_load  (seed_load),
    .seed_d1    (seed_d1),
    .seed_d2    (seed_d2),
    .seed_d3    (seed_d3),
    .trng_rst   (trng_rst),
    .trng_d1    (trng_d1),
    .trng_d2    (trng_d2),
    .trng_d3    (trng_d3),
    .trng_valid (trng_valid),
    .trng_bit   (trng_bit),
    .req        (req),
    .gnt        (gnt),
    .rnd_data   (rnd_data),
    .rnd_valid  (rnd_valid),
    .fifo_level (fifo_level),
    .fault      (fault),
    .st         (st)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit gap);
    trng_valid = 1'b1;
    trng_bit   = b;
    cycle();
    trng_valid = 1'b0;
    if (gap) cycle();
  endtask

  task automatic feed_word(input logic [WORD_W-1:0] w, input bit gap);
    for (int i = WORD_W - 1; i >= 0; i--) send_bit(w[i], gap);
  endtask

  task automatic pop_expected();
    if (sb_q.size() != 0) exp_w = sb_q.pop_front();
    else exp_w = 'x;
  endtask

  task automatic bring_up();
    seed_load = 1'b1;
    cycle();
    seed_load = 1'b0;
    repeat (8) cycle();
    for (int k = 0; k < 256; k++) send_bit(logic'(k & 1), 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 4'b1111;
    repeat (3) cycle();
    total++; if (trng_rst !== 1'b1) $display("FAIL reset_trng_rst_held: got %b expected 1", trng_rst); else passed++;
    rst = 1'b1;
    repeat (100) cycle();
    #1;
    total++; if (st !== 3'(ST_IDLE)) $display("FAIL reset_st: got %0d expected %0d", st, ST_IDLE); else passed++;
    total++; if (trng_rst !== 1'b1) $display("FAIL reset_trng_rst: got %b expected 1", trng_rst); else passed++;
    total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b expected 0000", gnt); else passed++;
    total++; if (rnd_valid !== 1'b0 || rnd_data !== '0) $display("FAIL reset_rnd: got v=%b d=%h expected v=0 d=0", rnd_valid, rnd_data); else passed++;
    total++; if (fifo_level !== '0 || fault !== 1'b0) $display("FAIL reset_level_fault: got lvl=%0d f=%b expected 0/0", fifo_level, fault); else passed++;
    total++; if ({trng_d1, trng_d2, trng_d3} !== 7'd0) $display("FAIL reset_seeds: got %b expected 0", {trng_d1, trng_d2, trng_d3}); else passed++;
    req = '0;
  endtask

  task automatic test_reseed();
    int n;
    seed_d1 = 1'b1; seed_d2 = 1'b0; seed_d3 = 5'h15;
    seed_load = 1'b1;
    cycle();
    seed_load = 1'b0;
    seed_d3 = 5'h0A;
    total++; if (st !== 3'(ST_RESEED)) $display("FAIL reseed_st: got %0d expected %0d", st, ST_RESEED); else passed++;
    n = 0;
    while (trng_rst === 1'b1 && n < 40) begin
      n++;
      cycle();
    end
    total++; if (n != 8) $display("FAIL reseed_rst_cycles: got %0d expected 8", n); else passed++;
    total++; if (trng_d3 !== 5'h15 || trng_d1 !== 1'b1) $display("FAIL reseed_seed: got d1=%b d3=%h expected 1/15", trng_d1, trng_d3); else passed++;
    total++; if (st !== 3'(ST_WARMUP)) $display("FAIL reseed_warmup_st: got %0d expected %0d", st, ST_WARMUP); else passed++;
    for (int k = 0; k < 255; k++) send_bit(logic'(k & 1), (k % 3) == 0);
    total++; if (st !== 3'(ST_WARMUP) || fifo_level !== '0) $display("FAIL warmup_255: got st=%0d lvl=%0d expected %0d/0", st, fifo_level, ST_WARMUP); else passed++;
    send_bit(1'b1, 1'b0);
    total++; if (st !== 3'(ST_RUN) || fifo_level !== '0) $display("FAIL warmup_256: got st=%0d lvl=%0d expected %0d/0", st, fifo_level, ST_RUN); else passed++;
  endtask

  task automatic test_packing();
    feed_word(32'hAAAA_AAAA, 1'b1);
    sb_q.push_back(32'hAAAA_AAAA);
    total++; if (fifo_level !== 3'd1) $display("FAIL pack_level: got %0d expected 1", fifo_level); else passed++;
    req = 4'b1000;
    #1;
    pop_expected();
    total++; if (gnt !== 4'b1000 || rnd_valid !== 1'b1) $display("FAIL pack_gnt: got %b v=%b expected 1000 v=1", gnt, rnd_valid); else passed++;
    total++; if (rnd_data !== exp_w) $display("FAIL pack_word: got %h expected %h", rnd_data, exp_w); else passed++;
    cycle();
    req = '0;
    total++; if (fifo_level !== 3'd0) $display("FAIL pack_pop_level: got %0d expected 0", fifo_level); else passed++;
  endtask

  task automatic test_round_robin();
    logic [WORD_W-1:0] words [4];
    int exp_idx [4];
    words   = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h0F0F_3C3C, 32'h5A5A_C3C3};
    exp_idx = '{0, 1, 3, 0};
    for (int k = 0; k < 4; k++) begin
      feed_word(words[k], 1'b0);
      sb_q.push_back(words[k]);
    end
    total++; if (fifo_level !== 3'd4) $display("FAIL rr_fill_level: got %0d expected 4", fifo_level); else passed++;
    req = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      #1;
      pop_expected();
      total++; if (gnt !== 4'(1 << exp_idx[k])) $display("FAIL rr_gnt%0d: got %b expected %b", k, gnt, 4'(1 << exp_idx[k])); else passed++;
      total++; if (rnd_data !== exp_w) $display("FAIL rr_word%0d: got %h expected %h", k, rnd_data, exp_w); else passed++;
      total++; if (fifo_level !== 3'(4 - k)) $display("FAIL rr_level%0d: got %0d expected %0d", k, fifo_level, 4 - k); else passed++;
      cycle();
    end
    #1;
    total++; if (gnt !== 4'b0000 || fifo_level !== 3'd0) $display("FAIL rr_empty: got gnt=%b lvl=%0d expected 0000/0", gnt, fifo_level); else passed++;
    req = '0;
  endtask

  task automatic test_full();
    logic [WORD_W-1:0] w [7];
    for (int k = 0; k < 7; k++) w[k] = ($urandom & 32'hFFFF_0000) | 32'h0000_5A5A;
    for (int k = 0; k < 5; k++) begin
      feed_word(w[k], 1'b0);
      if (sb_q.size() < FIFO_D) sb_q.push_back(w[k]);
    end
    total++; if (fifo_level !== 3'd4) $display("FAIL full_level: got %0d expected 4", fifo_level); else passed++;
    req = 4'b0010;
    #1;
    pop_expected();
    total++; if (gnt !== 4'b0010 || rnd_data !== exp_w) $display("FAIL full_pop: got gnt=%b d=%h expected 0010/%h", gnt, rnd_data, exp_w); else passed++;
    cycle();
    req = '0;
    feed_word(w[5], 1'b0);
    if (sb_q.size() < FIFO_D) sb_q.push_back(w[5]);
    total++; if (fifo_level !== 3'd4) $display("FAIL full_refill: got %0d expected 4", fifo_level); else passed++;
    for (int i = WORD_W - 1; i >= 1; i--) send_bit(w[6][i], 1'b0);
    trng_valid = 1'b1;
    trng_bit   = w[6][0];
    req        = 4'b0100;
    #1;
    pop_expected();
    total++; if (gnt !== 4'b0100 || rnd_data !== exp_w) $display("FAIL full_pushpop: got gnt=%b d=%h expected 0100/%h", gnt, rnd_data, exp_w); else passed++;
    sb_q.push_back(w[6]);
    cycle();
    trng_valid = 1'b0;
    req = '0;
    total++; if (fifo_level !== 3'd4) $display("FAIL full_pushpop_level: got %0d expected 4", fifo_level); else passed++;
    req = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      #1;
      pop_expected();
      total++; if (gnt !== 4'b0001 || rnd_data !== exp_w) $display("FAIL full_drain%0d: got gnt=%b d=%h expected 0001/%h", k, gnt, rnd_data, exp_w); else passed++;
      cycle();
    end
    req = '0;
    total++; if (fifo_level !== 3'd0) $display("FAIL full_drain_level: got %0d expected 0", fifo_level); else passed++;
  endtask

  task automatic test_fault();
    feed_word(32'hA5A5_A5A5, 1'b0);
    sb_q.push_back(32'hA5A5_A5A5);
    for (int k = 0; k < 31; k++) send_bit(1'b0, 1'b0);
    total++; if (st !== 3'(ST_RUN) || fifo_level !== 3'd1) $display("FAIL fault_31: got st=%0d lvl=%0d expected %0d/1", st, fifo_level, ST_RUN); else passed++;
    send_bit(1'b0, 1'b0);
    sb_q.delete();
    total++; if (st !== 3'(ST_FAULT) || fault !== 1'b1) $display("FAIL fault_32: got st=%0d f=%b expected %0d/1", st, fault, ST_FAULT); else passed++;
    total++; if (fifo_level !== 3'd0 || trng_rst !== 1'b1) $display("FAIL fault_flush: got lvl=%0d rst=%b expected 0/1", fifo_level, trng_rst); else passed++;
    req = 4'b1111;
    repeat (3) cycle();
    #1;
    total++; if (gnt !== 4'b0000 || st !== 3'(ST_FAULT)) $display("FAIL fault_hold: got gnt=%b st=%0d expected 0000/%0d", gnt, st, ST_FAULT); else passed++;
    req = '0;
    seed_load = 1'b1;
    cycle();
    seed_load = 1'b0;
    total++; if (st !== 3'(ST_RESEED) || fault !== 1'b0) $display("FAIL fault_exit: got st=%0d f=%b expected %0d/0", st, fault, ST_RESEED); else passed++;
  endtask

  task automatic test_seed_flush();
    bring_up();
    feed_word(32'h3C3C_5A5A, 1'b0);
    total++; if (fifo_level !== 3'd1) $display("FAIL seedflush_level: got %0d expected 1", fifo_level); else passed++;
    seed_load = 1'b1;
    req = 4'b0001;
    #1;
    total++; if (gnt !== 4'b0000 || rnd_valid !== 1'b0) $display("FAIL seedflush_gnt: got %b v=%b expected 0000 v=0", gnt, rnd_valid); else passed++;
    cycle();
    seed_load = 1'b0;
    req = '0;
    total++; if (fifo_level !== 3'd0 || st !== 3'(ST_RESEED)) $display("FAIL seedflush_after: got lvl=%0d st=%0d expected 0/%0d", fifo_level, st, ST_RESEED); else passed++;
  endtask

  task automatic test_async_reset();
    repeat (10) cycle();
    total++; if (st !== 3'(ST_WARMUP) || trng_rst !== 1'b0) $display("FAIL areset_pre: got st=%0d rst=%b expected %0d/0", st, trng_rst, ST_WARMUP); else passed++;
    #2;
    rst = 1'b0;
    #1;
    total++; if (st !== 3'(ST_IDLE) || trng_rst !== 1'b1) $display("FAIL areset_now: got st=%0d rst=%b expected %0d/1", st, trng_rst, ST_IDLE); else passed++;
    cycle();
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_reseed();
    test_packing();
    test_round_robin();
    test_full();
    test_fault();
    test_seed_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
